// File: rtl/counter_timer_ctrl_if.sv
// Command/config and status bundle for counter_timer_ctrl.
// The controller takes the slave side; whatever drives commands takes the master side.
interface counter_timer_ctrl_if #(
  parameter int WIDTH = 4,
  parameter int PW    = 4
);
  logic             cfg_we;
  logic [WIDTH-1:0] cfg_period;
  logic [PW-1:0]    cfg_prescale;
  logic             cfg_periodic;
  logic             start;
  logic             stop;
  logic             pause;
  logic             irq_ack;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             tc;
  logic             irq;
  logic [1:0]       state;

  modport master (
    output cfg_we, cfg_period, cfg_prescale, cfg_periodic,
    output start, stop, pause, irq_ack,
    input  count, busy, tc, irq, state
  );

  modport slave (
    input  cfg_we, cfg_period, cfg_prescale, cfg_periodic,
    input  start, stop, pause, irq_ack,
    output count, busy, tc, irq, state
  );
endinterface

// File: rtl/counter_timer_ctrl.sv
// Programmable timer: prescaled count up to a terminal period, one-shot or periodic,
// with a registered terminal-count pulse and a sticky acknowledged interrupt.
module counter_timer_ctrl #(
  parameter int WIDTH = 4,
  parameter int PW    = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  counter_timer_ctrl_if.slave  bus
);

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_RUN  = 2'b01;
  localparam logic [1:0] S_HOLD = 2'b10;
  localparam logic [1:0] S_DONE = 2'b11;

  typedef struct packed {
    logic [WIDTH-1:0] period;
    logic [PW-1:0]    prescale;
    logic             periodic;
  } cfg_t;

  cfg_t             cfg_q, cfg_d;
  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [PW-1:0]    pc_q, pc_d;
  logic             tc_q, tc_d;
  logic             irq_q, irq_d;
  logic             term;

  always_comb begin
    cfg_d   = cfg_q;
    state_d = state_q;
    count_d = count_q;
    pc_d    = pc_q;
    term    = 1'b0;

    // Config is frozen outside IDLE; a same-cycle start runs with the new values.
    if (state_q == S_IDLE && bus.cfg_we) begin
      cfg_d.period   = bus.cfg_period;
      cfg_d.prescale = bus.cfg_prescale;
      cfg_d.periodic = bus.cfg_periodic;
    end

    unique case (state_q)
      S_IDLE: begin
        count_d = '0;
        pc_d    = '0;
        if (!bus.stop && bus.start) state_d = S_RUN;
      end
      S_RUN: begin
        if (bus.stop) begin
          state_d = S_IDLE;
          count_d = '0;
          pc_d    = '0;
        end else if (bus.pause) begin
          state_d = S_HOLD;
        end else if (pc_q == cfg_q.prescale) begin
          pc_d = '0;
          if (count_q == cfg_q.period) begin
            term = 1'b1;
            if (cfg_q.periodic) count_d = '0;
            else                state_d = S_DONE;
          end else begin
            count_d = count_q + WIDTH'(1);
          end
        end else begin
          pc_d = pc_q + PW'(1);
        end
      end
      S_HOLD: begin
        if (bus.stop) begin
          state_d = S_IDLE;
          count_d = '0;
          pc_d    = '0;
        end else if (!bus.pause) begin
          state_d = S_RUN;
        end
      end
      default: begin
        if (bus.stop) begin
          state_d = S_IDLE;
          count_d = '0;
          pc_d    = '0;
        end else if (bus.start) begin
          state_d = S_RUN;
          count_d = '0;
          pc_d    = '0;
        end
      end
    endcase

    tc_d  = term;
    // A terminal count beats a coincident acknowledge.
    irq_d = term | (irq_q & ~bus.irq_ack);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cfg_q.period   <= '1;
      cfg_q.prescale <= '0;
      cfg_q.periodic <= 1'b0;
      state_q        <= S_IDLE;
      count_q        <= '0;
      pc_q           <= '0;
      tc_q           <= 1'b0;
      irq_q          <= 1'b0;
    end else begin
      cfg_q   <= cfg_d;
      state_q <= state_d;
      count_q <= count_d;
      pc_q    <= pc_d;
      tc_q    <= tc_d;
      irq_q   <= irq_d;
    end
  end

  assign bus.count = count_q;
  assign bus.state = state_q;
  assign bus.busy  = (state_q == S_RUN) || (state_q == S_HOLD);
  assign bus.tc    = tc_q;
  assign bus.irq   = irq_q;

endmodule

// File: tb/tb_counter_timer_ctrl.sv
// Self-checking bench: directed scenarios plus random commands, every cycle compared
// against an elapsed-time reference model of the timer.
module tb_counter_timer_ctrl;
  localparam int WIDTH = 4;
  localparam int PW    = 4;

  logic clk = 1'b0;
  logic reset;

  counter_timer_ctrl_if #(.WIDTH(WIDTH), .PW(PW)) bus ();

  counter_timer_ctrl #(.WIDTH(WIDTH), .PW(PW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: the run is described by how many counting clocks t have elapsed
  // since the (re)start; count and terminal events follow from arithmetic on t.
  typedef enum int {M_IDLE, M_RUN, M_HOLD, M_DONE} mmode_e;
  mmode_e m_mode;
  int     m_t, m_n, m_p, m_per;
  bit     m_tc, m_irq;

  function automatic int spec_state(input mmode_e m);
    case (m)
      M_IDLE:  return 0;
      M_RUN:   return 1;
      M_HOLD:  return 2;
      default: return 3;
    endcase
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_t = 0; m_n = 15; m_p = 0; m_per = 0; m_tc = 0; m_irq = 0;
  endtask

  task automatic model_edge();
    int len;
    m_tc = 0;
    if (m_mode == M_IDLE && bus.cfg_we) begin
      m_n = int'(bus.cfg_period); m_p = int'(bus.cfg_prescale); m_per = int'(bus.cfg_periodic);
    end
    if (bus.stop) begin
      m_mode = M_IDLE; m_t = 0;
    end else if (bus.start && (m_mode == M_IDLE || m_mode == M_DONE)) begin
      m_mode = M_RUN; m_t = 0;
    end else if (m_mode == M_RUN && bus.pause) begin
      m_mode = M_HOLD;
    end else if (m_mode == M_HOLD && !bus.pause) begin
      m_mode = M_RUN;
    end else if (m_mode == M_RUN) begin
      len = (m_n + 1) * (m_p + 1);
      m_t++;
      if (m_t == len) begin
        m_tc = 1;
        if (m_per != 0) m_t = 0;
        else            m_mode = M_DONE;
      end
    end
    if (m_tc)             m_irq = 1;
    else if (bus.irq_ack) m_irq = 0;
  endtask

  task automatic check_all();
    int c;
    c = m_t / (m_p + 1);
    if (c > m_n) c = m_n;
    chk("count", 32'(bus.count), 32'(c));
    chk("state", 32'(bus.state), 32'(spec_state(m_mode)));
    chk("busy",  32'(bus.busy),  32'(m_mode == M_RUN || m_mode == M_HOLD));
    chk("tc",    32'(bus.tc),    32'(m_tc));
    chk("irq",   32'(bus.irq),   32'(m_irq));
  endtask

  // One clock: model and DUT see the same inputs at the edge, then pulses are cleared.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
    bus.start = 0; bus.stop = 0; bus.cfg_we = 0; bus.irq_ack = 0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic cfg_start(input int n, input int p, input int per, input bit with_start);
    bus.cfg_we = 1; bus.cfg_period = WIDTH'(n); bus.cfg_prescale = PW'(p);
    bus.cfg_periodic = per[0]; bus.start = with_start;
    tick();
  endtask

  task automatic async_reset();
    #3;
    reset = 0;
    model_reset();
    #1;
    chk("rst_count", 32'(bus.count), 32'(0));
    chk("rst_state", 32'(bus.state), 32'(0));
    chk("rst_irq",   32'(bus.irq),   32'(0));
    chk("rst_tc",    32'(bus.tc),    32'(0));
    #1;
    reset = 1;
  endtask

  initial begin
    bus.cfg_we = 0; bus.cfg_period = '0; bus.cfg_prescale = '0; bus.cfg_periodic = 0;
    bus.start = 0; bus.stop = 0; bus.pause = 0; bus.irq_ack = 0;
    reset = 0;
    model_reset();
    #12;
    reset = 1;
    check_all();

    // One-shot N=3 P=0: tc right after the 4th edge from start.
    cfg_start(3, 0, 0, 1);
    ticks(3);
    chk("os_count3", 32'(bus.count), 32'(3));
    tick();
    chk("os_tc", 32'(bus.tc), 32'(1));
    chk("os_state", 32'(bus.state), 32'(3));
    ticks(3);
    chk("os_irq_held", 32'(bus.irq), 32'(1));
    bus.irq_ack = 1; tick();
    chk("os_ack", 32'(bus.irq), 32'(0));
    bus.stop = 1; tick();

    // Periodic N=15: ack coincident with terminal count leaves irq set.
    cfg_start(15, 0, 1, 1);
    ticks(15);
    bus.irq_ack = 1; tick();
    chk("per_ack_tc", 32'(bus.irq), 32'(1));
    ticks(20);
    bus.irq_ack = 1; tick();
    chk("per_ack", 32'(bus.irq), 32'(0));
    ticks(12);
    bus.stop = 1; tick();

    // N=2 P=2 one-shot: tc after the 9th edge.
    cfg_start(2, 2, 0, 1);
    ticks(8);
    chk("ps_no_tc", 32'(bus.tc), 32'(0));
    tick();
    chk("ps_tc", 32'(bus.tc), 32'(1));
    bus.stop = 1; tick();

    // Pause at count 2, then stop together with pause.
    cfg_start(5, 0, 0, 1);
    ticks(2);
    bus.pause = 1;
    ticks(5);
    chk("hold_state", 32'(bus.state), 32'(2));
    chk("hold_count", 32'(bus.count), 32'(2));
    bus.pause = 0;
    ticks(2);
    chk("resume_count", 32'(bus.count), 32'(3));
    bus.pause = 1; tick();
    bus.stop = 1; tick();
    bus.pause = 0;
    chk("stop_state", 32'(bus.state), 32'(0));

    // Config write during a run is ignored; in IDLE with start it takes effect.
    cfg_start(5, 0, 0, 1);
    tick();
    cfg_start(1, 0, 0, 0);
    ticks(6);
    chk("cfg_ign_state", 32'(bus.state), 32'(3));
    bus.stop = 1; tick();
    cfg_start(1, 0, 0, 1);
    ticks(2);
    chk("cfg_new_tc", 32'(bus.tc), 32'(1));

    // Mid-run asynchronous reset, then defaults: N=15, P=0, one-shot.
    cfg_start(7, 1, 1, 1);
    ticks(5);
    async_reset();
    bus.start = 1; tick();
    ticks(16);
    chk("dflt_tc", 32'(bus.tc), 32'(1));
    chk("dflt_state", 32'(bus.state), 32'(3));

    // Random commands against the model.
    for (int i = 0; i < 4000; i++) begin
      bus.cfg_we       = ($urandom_range(0, 5) == 0);
      bus.cfg_period   = ($urandom_range(0, 7) == 0) ? WIDTH'($urandom_range(0, 15))
                                                     : WIDTH'($urandom_range(0, 4));
      bus.cfg_prescale = PW'($urandom_range(0, 3));
      bus.cfg_periodic = $urandom_range(0, 1) == 1;
      bus.start        = ($urandom_range(0, 4) == 0);
      bus.stop         = ($urandom_range(0, 40) == 0);
      bus.irq_ack      = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 9) == 0) bus.pause = ~bus.pause;
      tick();
      if ($urandom_range(0, 600) == 0) async_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/counter_timer_ctrl.md
Name: counter_timer_ctrl

Overview:
Controller that sequences the free-running count datapath as a programmable timer. It holds configuration (terminal period, prescale divider, one-shot/periodic mode) and runs the count through an IDLE/RUN/HOLD/DONE state machine. It raises a terminal-count pulse and a sticky interrupt with acknowledge handshake. Sits between the control/config logic and any consumer of the count value.

Parameters:
WIDTH, 4, count and period width in bits
PW, 4, prescale divider width in bits

Ports:
clk  in  1  system clock, all state changes on rising edge
reset  in  1  asynchronous, active-low reset
cfg_we  in  1  config write strobe, honoured only in IDLE
cfg_period  in  WIDTH  terminal count value N
cfg_prescale  in  PW  count advances once every P+1 clocks
cfg_periodic  in  1  1 = auto-restart at terminal count, 0 = one-shot
start  in  1  start request, single-cycle pulse
stop  in  1  abort request, single-cycle pulse
pause  in  1  level, freezes the count while high
irq_ack  in  1  clears irq
count  out  WIDTH  current count value
busy  out  1  high in RUN or HOLD; decoded from state
tc  out  1  registered single-cycle terminal-count pulse
irq  out  1  sticky interrupt
state  out  2  IDLE=00, RUN=01, HOLD=10, DONE=11

Behaviour:
- Reset asserted (low) acts immediately, with no clock edge. It sets: state IDLE, count 0, prescale counter pc 0, tc 0, irq 0, period = all ones, prescale 0, periodic 0.
- Config registers load on the edge where cfg_we=1 and state is IDLE. cfg_we in any other state is ignored; a running timer never sees config change.
- If cfg_we and start are both high in IDLE, the new config is written and the run uses it.
- Command priority within a cycle: stop > start > pause > step.
- IDLE:
  - count held at 0.
  - start -> RUN with count 0 and pc 0.
- RUN:
  - Each clock, pc increments.
  - When pc==P, a step occurs: pc returns to 0.
  - On a step with count<N: count+1.
  - On a step with count==N: tc=1 for the next cycle and irq is set. Periodic mode: count returns to 0 and state stays RUN. One-shot mode: count holds N and state goes to DONE.
- Terminal-count latency: tc is high after edge (N+1)*(P+1) counted from the start edge. N=0 gives a tc every P+1 clocks.
- pause high in RUN -> HOLD.
- HOLD:
  - count and pc frozen; tc not generated.
  - pause low -> RUN, resuming from the frozen pc and count.
- stop in RUN, HOLD or DONE -> IDLE with count 0 and pc 0. No tc is produced. irq is unchanged.
- start while in RUN or HOLD is ignored.
- DONE:
  - count holds N; busy 0.
  - start -> RUN restarting from 0.
  - stop -> IDLE.
- irq handshake:
  - Set by a terminal count; cleared by irq_ack; otherwise held.
  - If a terminal count and irq_ack occur in the same cycle, set wins.
  - irq is independent of state transitions.
- count never exceeds N, so there is no WIDTH overflow. N = 2^WIDTH-1 wraps 15->0 in periodic mode.
- Reset asserted mid-run aborts immediately; no tc or irq is produced.

Test Plan:
- One-shot, N=3, P=0, start at edge E0 -> count 1,2,3 at E1..E3. tc=1 for exactly the cycle after E4, state=11, count stays 3, irq=1 until irq_ack, busy=0.
- Periodic, N=15, P=0, no ack -> count 0..15,0..; tc every 16 clocks; irq stays 1. irq_ack coincident with a tc -> irq remains 1. Ack on a non-tc cycle -> irq 0.
- N=2, P=2, one-shot -> count advances every 3 clocks; tc after the 9th edge from start; irq=1.
- Pause held 5 clocks at count=2 -> state=10, count stays 2, busy=1, tc stays 0. Release -> resumes at 2. stop together with pause -> state=00, count=0, irq unchanged.
- cfg_we with period=1 during a run programmed with N=5 -> ignored; tc still occurs at count 5. The same write in IDLE together with start -> run uses N=1.
- Reset driven low mid-run between clock edges -> count=0, state=00, irq=0, tc=0 immediately, before any further clock edge. After release, period=15, P=0, one-shot.
